// File: rtl/aes_pkg.sv
// Shared AES constants and helpers: S-box, xtime, Rcon, round count, FSM states.
package aes_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StDone} aes_state_e;

    // Forward S-box, byte 0x00 in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        // Entry x sits at bit 8*(255-x)+7 downward.
        return SBOX_TBL[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic int unsigned nr(input int unsigned key_bits);
        return (key_bits == 256) ? 14 : 10;
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] rk,
    input  logic         skip_mix,
    output logic [127:0] next
);

    logic [7:0] w_sb [16];
    logic [7:0] w_sr [16];
    logic [7:0] w_mc [16];

    // SubBytes then ShiftRows; byte index is 4*column + row.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_sb[i] = sbox(state[127-8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sr[4*c+r] = w_sb[4*((c+r)%4)+r];
            end
        end
    end

    // MixColumns per column, then AddRoundKey (MixColumns bypassed in the final round).
    always_comb begin
        next = '0;
        for (int c = 0; c < 4; c++) begin
            w_mc[4*c+0] = xtime(w_sr[4*c+0]) ^ xtime(w_sr[4*c+1]) ^ w_sr[4*c+1]
                        ^ w_sr[4*c+2] ^ w_sr[4*c+3];
            w_mc[4*c+1] = w_sr[4*c+0] ^ xtime(w_sr[4*c+1]) ^ xtime(w_sr[4*c+2])
                        ^ w_sr[4*c+2] ^ w_sr[4*c+3];
            w_mc[4*c+2] = w_sr[4*c+0] ^ w_sr[4*c+1] ^ xtime(w_sr[4*c+2])
                        ^ xtime(w_sr[4*c+3]) ^ w_sr[4*c+3];
            w_mc[4*c+3] = xtime(w_sr[4*c+0]) ^ w_sr[4*c+0] ^ w_sr[4*c+1]
                        ^ w_sr[4*c+2] ^ xtime(w_sr[4*c+3]);
        end
        for (int i = 0; i < 16; i++) begin
            next[127-8*i -: 8] = (skip_mix ? w_sr[i] : w_mc[i]) ^ rk[127-8*i -: 8];
        end
    end

endmodule

// File: rtl/aes_iter_encrypt.sv
// Iterative AES-128/256 encryptor: one round per clock, round keys expanded on the fly.
module aes_iter_encrypt
    import aes_pkg::*;
#(
    parameter int unsigned KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        datain,
    input  logic [KEY_BITS-1:0] key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        dataout
);

    localparam int unsigned NR       = nr(KEY_BITS);
    localparam logic [3:0]  LAST_RND = 4'(NR);

    aes_state_e          r_state, w_state_next;
    logic [127:0]        r_blk, r_dout, w_round_out;
    logic [KEY_BITS-1:0] r_key, w_key_next;
    logic [3:0]          r_rnd, w_rc_idx;
    logic                w_accept, w_last_rnd, w_rot;
    logic [127:0]        w_prev, w_rk_new, w_rk;
    logic [31:0]         w_last, w_rotw, w_t, w_k0, w_k1, w_k2, w_k3;

    assign w_accept   = in_valid & in_ready;
    assign w_last_rnd = (r_rnd == LAST_RND);
    assign out_valid  = (r_state == StDone);
    assign dataout    = r_dout;

    // Next key words: w_prev holds w[i-Nk..], w_last holds w[i-1]. AES-256 rotates only on
    // even rounds (i%8==0) and does SubWord alone on odd rounds (i%8==4).
    always_comb begin
        w_prev   = r_key[KEY_BITS-1 -: 128];
        w_last   = r_key[31:0];
        w_rot    = (KEY_BITS == 128) || !r_rnd[0];
        w_rc_idx = (KEY_BITS == 128) ? r_rnd : {1'b0, r_rnd[3:1]};
        w_rotw   = w_rot ? {w_last[23:0], w_last[31:24]} : w_last;
        w_t      = {sbox(w_rotw[31:24]), sbox(w_rotw[23:16]),
                    sbox(w_rotw[15:8]), sbox(w_rotw[7:0])};
        if (w_rot) begin
            w_t = w_t ^ {rcon(w_rc_idx), 24'h0};
        end
        w_k0     = w_prev[127:96] ^ w_t;
        w_k1     = w_prev[95:64] ^ w_k0;
        w_k2     = w_prev[63:32] ^ w_k1;
        w_k3     = w_prev[31:0] ^ w_k2;
        w_rk_new = {w_k0, w_k1, w_k2, w_k3};
        // AES-256 round 1 uses the second key half as-is.
        w_rk     = (KEY_BITS == 256 && r_rnd == 4'd1) ? r_key[127:0] : w_rk_new;
    end

    if (KEY_BITS == 128) begin : g_key128
        assign w_key_next = w_rk_new;
    end else if (KEY_BITS == 256) begin : g_key256
        // Window slides {rk[r-2], rk[r-1]} -> {rk[r-1], rk[r]}; held through round 1.
        assign w_key_next = (r_rnd == 4'd1) ? r_key : {r_key[127:0], w_rk_new};
    end else begin : g_bad_key_bits
        $error("aes_iter_encrypt: KEY_BITS must be 128 or 256");
    end

    aes_round u_round (
        .state    (r_blk),
        .rk       (w_rk),
        .skip_mix (w_last_rnd),
        .next     (w_round_out)
    );

    // FSM next state and input handshake.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        unique case (r_state)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = StRun;
            end
            StRun: begin
                if (w_last_rnd) w_state_next = StDone;
            end
            StDone: begin
                in_ready = out_ready;
                if (out_ready) w_state_next = in_valid ? StRun : StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_next;
    end

    // Datapath: load on accept, iterate one round per cycle in RUN, capture the final round.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blk  <= '0;
            r_key  <= '0;
            r_rnd  <= '0;
            r_dout <= '0;
        end else if (w_accept) begin
            r_blk <= datain ^ key[KEY_BITS-1 -: 128];
            r_key <= key;
            r_rnd <= 4'd1;
        end else if (r_state == StRun) begin
            r_blk <= w_round_out;
            r_key <= w_key_next;
            r_rnd <= r_rnd + 4'd1;
            if (w_last_rnd) r_dout <= w_round_out;
        end
    end

endmodule

// File: tb/tb_aes_iter_encrypt.sv
// Self-checking bench: FIPS-197 vectors, backpressure/hand-off, mid-run reset, random regression.
module tb_aes_iter_encrypt;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         iv_a, ir_a, ov_a, or_a;
    logic [127:0] din_a, key_a, dout_a;
    logic         iv_b, ir_b, ov_b, or_b;
    logic [127:0] din_b, dout_b;
    logic [255:0] key_b;

    aes_iter_encrypt #(.KEY_BITS(128)) u_dut128 (
        .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .datain(din_a),
        .key(key_a), .out_valid(ov_a), .out_ready(or_a), .dataout(dout_a)
    );

    aes_iter_encrypt #(.KEY_BITS(256)) u_dut256 (
        .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .datain(din_b),
        .key(key_b), .out_valid(ov_b), .out_ready(or_b), .dataout(dout_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (FIPS-197 pseudocode over byte arrays) -------------
    logic [7:0] sb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box from the GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        for (int v = 0; v < 256; v++) begin
            logic [7:0] x, inv;
            x   = 8'(v);
            inv = 8'h00;
            if (x != 8'h00) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gmul(inv, x);
            end
            sb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // key is left-aligned in 256 bits; nk = 4 or 8.
    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [255:0] key,
                                             input int nk);
        logic [31:0]  w [60];
        logic [7:0]   st [16];
        logic [7:0]   tmp [16];
        logic [31:0]  t, kw;
        logic [7:0]   rc;
        logic [127:0] res;
        int           nrr;
        nrr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < 4 * (nrr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8];
        for (int c = 0; c < 4; c++) begin
            kw = w[c];
            for (int j = 0; j < 4; j++) st[4*c+j] = st[4*c+j] ^ kw[31-8*j -: 8];
        end
        for (int r = 1; r <= nrr; r++) begin
            for (int i = 0; i < 16; i++) st[i] = sb[st[i]];
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++) tmp[4*c+j] = st[4*((c+j)%4)+j];
            for (int c = 0; c < 4; c++) begin
                for (int j = 0; j < 4; j++) begin
                    if (r < nrr)
                        st[4*c+j] = gmul(8'h02, tmp[4*c+j]) ^ gmul(8'h03, tmp[4*c+(j+1)%4])
                                  ^ tmp[4*c+(j+2)%4] ^ tmp[4*c+(j+3)%4];
                    else
                        st[4*c+j] = tmp[4*c+j];
                end
                kw = w[4*r+c];
                for (int j = 0; j < 4; j++) st[4*c+j] = st[4*c+j] ^ kw[31-8*j -: 8];
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
        return res;
    endfunction

    // ---------------- DUT access helpers (sel: 0 = AES-128, 1 = AES-256) ----------------
    function automatic logic get_ov(input bit sel);
        return sel ? ov_b : ov_a;
    endfunction
    function automatic logic get_ir(input bit sel);
        return sel ? ir_b : ir_a;
    endfunction
    function automatic logic [127:0] get_dout(input bit sel);
        return sel ? dout_b : dout_a;
    endfunction

    task automatic drive_in(input bit sel, input logic v, input logic [127:0] pt,
                            input logic [255:0] k);
        if (sel) begin
            iv_b = v; din_b = pt; key_b = k;
        end else begin
            iv_a = v; din_a = pt; key_a = k[255:128];
        end
    endtask

    task automatic set_or(input bit sel, input logic v);
        if (sel) or_b = v;
        else     or_a = v;
    endtask

    // Count posedges from the accept edge until out_valid; leaves the DUT in DONE.
    task automatic wait_result(input bit sel, input logic [127:0] exp, input string tag);
        int lat;
        lat = 0;
        while (!get_ov(sel) && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 128'(lat), sel ? 128'd14 : 128'd10);
        check({tag, "_dataout"}, get_dout(sel), exp);
    endtask

    task automatic run_block(input bit sel, input logic [127:0] pt, input logic [255:0] k,
                             input logic [127:0] exp, input string tag);
        int waits;
        @(negedge clk);
        set_or(sel, 1'b0);
        drive_in(sel, 1'b1, pt, k);
        #1;
        waits = 0;
        while (!get_ir(sel) && waits < 40) begin
            @(negedge clk);
            #1;
            waits++;
        end
        check({tag, "_in_ready"}, 128'(get_ir(sel)), 128'd1);
        @(negedge clk);
        drive_in(sel, 1'b0, '0, '0);
        wait_result(sel, exp, tag);
    endtask

    task automatic drain(input bit sel);
        @(negedge clk);
        set_or(sel, 1'b1);
        @(negedge clk);
        set_or(sel, 1'b0);
    endtask

    typedef struct {
        bit           is256;
        logic [127:0] pt;
        logic [255:0] key;
        logic [127:0] ct;
    } vec_t;

    vec_t         vecs [3];
    logic [127:0] exp_q [$];
    logic [127:0] pt_r, k_r, hold;
    int           sent, got, cyc, seen;

    initial begin
        vecs[0].is256 = 1'b0;
        vecs[0].pt    = 128'h3243f6a8885a308d313198a2e0370734;
        vecs[0].key   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        vecs[0].ct    = 128'h3925841d02dc09fbdc118597196a0b32;
        vecs[1].is256 = 1'b0;
        vecs[1].pt    = 128'h00112233445566778899aabbccddeeff;
        vecs[1].key   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        vecs[1].ct    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        vecs[2].is256 = 1'b1;
        vecs[2].pt    = 128'h00112233445566778899aabbccddeeff;
        vecs[2].key   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        vecs[2].ct    = 128'h8ea2b7ca516745bfeafc49904b496089;

        rst = 1'b1;
        drive_in(1'b0, 1'b0, '0, '0);
        drive_in(1'b1, 1'b0, '0, '0);
        or_a = 1'b0;
        or_b = 1'b0;
        build_sbox();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int s = 0; s < 2; s++) begin
            check($sformatf("reset_in_ready_%0d", s), 128'(get_ir(s[0])), 128'd1);
            check($sformatf("reset_out_valid_%0d", s), 128'(get_ov(s[0])), 128'd0);
            check($sformatf("reset_dataout_%0d", s), get_dout(s[0]), 128'd0);
        end

        for (int v = 0; v < 3; v++) begin
            run_block(vecs[v].is256, vecs[v].pt, vecs[v].key, vecs[v].ct,
                      $sformatf("vec%0d", v));
            drain(vecs[v].is256);
        end

        // Backpressure in DONE, then simultaneous hand-off of block 2.
        run_block(1'b0, vecs[0].pt, vecs[0].key, vecs[0].ct, "bp_blk1");
        hold = dout_a;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_stable_%0d", i), dout_a, hold);
            check($sformatf("bp_in_ready_%0d", i), 128'(ir_a), 128'd0);
            check($sformatf("bp_out_valid_%0d", i), 128'(ov_a), 128'd1);
        end
        @(negedge clk);
        or_a = 1'b1;
        drive_in(1'b0, 1'b1, vecs[1].pt, vecs[1].key);
        #1;
        check("handoff_in_ready", 128'(ir_a), 128'd1);
        @(negedge clk);
        or_a = 1'b0;
        drive_in(1'b0, 1'b0, '0, '0);
        check("handoff_out_valid_low", 128'(ov_a), 128'd0);
        wait_result(1'b0, vecs[1].ct, "handoff_blk2");
        drain(1'b0);

        // Reset while round 5 is being computed.
        @(negedge clk);
        drive_in(1'b0, 1'b1, vecs[0].pt, vecs[0].key);
        @(negedge clk);
        drive_in(1'b0, 1'b0, '0, '0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", 128'(ir_a), 128'd1);
        check("midrst_out_valid", 128'(ov_a), 128'd0);
        check("midrst_dataout", dout_a, 128'd0);
        seen = 0;
        repeat (16) begin
            @(negedge clk);
            if (ov_a) seen = 1;
        end
        check("midrst_no_output", 128'(seen), 128'd0);
        run_block(1'b0, vecs[1].pt, vecs[1].key, vecs[1].ct, "after_rst");
        drain(1'b0);

        // Random regression with input gaps and output stalls.
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < 1000 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            or_a = ($urandom_range(0, 3) != 0);
            if (ov_a && or_a) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rand_extra_output: got %h, expected no output", dout_a);
                end else begin
                    check($sformatf("rand_ct_%0d", got), dout_a, exp_q.pop_front());
                end
                got++;
            end
            pt_r = {$urandom, $urandom, $urandom, $urandom};
            k_r  = {$urandom, $urandom, $urandom, $urandom};
            iv_a = (sent < 1000) && ($urandom_range(0, 4) != 0);
            din_a = pt_r;
            key_a = k_r;
            #1;
            if (iv_a && ir_a) begin
                exp_q.push_back(aes_ref(pt_r, {k_r, 128'h0}, 4));
                sent++;
            end
        end
        iv_a = 1'b0;
        or_a = 1'b0;
        check("rand_received", 128'(got), 128'd1000);
        check("rand_leftover", 128'(exp_q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
